// File: rtl/mont_expo_192_pkg.sv
// Shared constants for the Montgomery modular exponentiator: default width,
// modulus, Montgomery constant and the controller state encoding.
package mont_expo_192_pkg;

    localparam int DEF_WIDTH = 192;
    localparam logic [191:0] DEF_MODULUS = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff;
    // 2^(2*192) mod DEF_MODULUS, used to move operands into Montgomery form.
    localparam logic [191:0] DEF_R2 = 192'h000000000000000100000000000000020000000000000001;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_PRE_X = 3'd1;
    localparam state_t ST_PRE_1 = 3'd2;
    localparam state_t ST_SQR   = 3'd3;
    localparam state_t ST_MUL   = 3'd4;
    localparam state_t ST_POST  = 3'd5;
    localparam state_t ST_DONE  = 3'd6;

endpackage

// File: rtl/mont_expo_192_mont_mult.sv
// Bit-serial radix-2 Montgomery multiplier: p = a*b*2^-W mod m.
// Requires b < m; a may be any W-bit value; the result is always < m.
module mont_mult
    import mont_expo_192_pkg::*;
#(
    parameter int W = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic [W-1:0] p,
    output logic         rdy
);

    // Handshake: go is a one-cycle request, accepted on the clock edge where
    // it is high (operands a and b are captured on that edge, m must stay
    // constant). Exactly W+1 edges later p is loaded and rdy pulses for one
    // cycle; p then holds until the next result. A new go may be issued in
    // the same cycle that rdy is high.
    localparam int CW = $clog2(W);

    logic [W+1:0] t;
    logic [W+1:0] sum_ab;
    logic [W+1:0] sum_m;
    logic [W+1:0] t_next;
    logic [W-1:0] t_red;
    logic [W-1:0] a_sh;
    logic [W-1:0] b_r;
    logic [CW-1:0] cnt;
    logic busy;
    logic fin;

    // The accumulator stays below 2m, so W+2 bits cover t + b + m.
    always_comb begin
        sum_ab = t + (a_sh[0] ? {2'b00, b_r} : '0);
        sum_m  = sum_ab[0] ? sum_ab + {2'b00, m} : sum_ab;
        t_next = sum_m >> 1;
        t_red  = (t >= {2'b00, m}) ? W'(t - {2'b00, m}) : W'(t);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t    <= '0;
            a_sh <= '0;
            b_r  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            fin  <= 1'b0;
            p    <= '0;
            rdy  <= 1'b0;
        end else begin
            rdy <= 1'b0;
            if (go) begin
                t    <= '0;
                a_sh <= a;
                b_r  <= b;
                cnt  <= '0;
                busy <= 1'b1;
                fin  <= 1'b0;
            end else if (busy) begin
                t    <= t_next;
                a_sh <= {1'b0, a_sh[W-1:1]};
                if (cnt == CW'(W - 1)) begin
                    busy <= 1'b0;
                    fin  <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (fin) begin
                fin <= 1'b0;
                p   <= t_red;
                rdy <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mont_expo_192.sv
// Left-to-right square-and-multiply exponentiator z = x^y mod MODULUS built
// around one shared Montgomery multiplier; the multiplier's result register is acc.
module mont_expo_192
    import mont_expo_192_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] MODULUS = DEF_MODULUS,
    parameter logic [WIDTH-1:0] R2 = DEF_R2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             start,
    output logic [WIDTH-1:0] z,
    output logic             done1,
    output state_t           dbg_state
);

    localparam int KW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH - 1){1'b0}}, 1'b1};

    state_t state;
    logic start_q;
    logic launch;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] xb;
    logic [WIDTH-1:0] acc;
    logic [KW-1:0] k;
    logic k_last;
    logic bit_set;
    logic mm_go;
    logic mm_rdy;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;

    assign dbg_state = state;

    // The next multiply is issued in the same cycle the previous result
    // appears, taking its operands straight from acc, so back-to-back
    // operations cost exactly one multiplier latency each.
    always_comb begin
        launch  = start & ~start_q & ((state == ST_IDLE) || (state == ST_DONE));
        k_last  = (k == '0);
        bit_set = y_r[k];
        mm_go   = 1'b0;
        mm_a    = '0;
        mm_b    = '0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (launch) begin
                    mm_go = 1'b1;
                    mm_a  = x;
                    mm_b  = R2;
                end
            end
            ST_PRE_X: begin
                if (mm_rdy) begin
                    mm_go = 1'b1;
                    mm_a  = ONE;
                    mm_b  = R2;
                end
            end
            ST_PRE_1: begin
                if (mm_rdy) begin
                    mm_go = 1'b1;
                    mm_a  = acc;
                    mm_b  = acc;
                end
            end
            ST_SQR: begin
                if (mm_rdy) begin
                    mm_go = 1'b1;
                    mm_a  = acc;
                    mm_b  = bit_set ? xb : (k_last ? ONE : acc);
                end
            end
            ST_MUL: begin
                if (mm_rdy) begin
                    mm_go = 1'b1;
                    mm_a  = acc;
                    mm_b  = k_last ? ONE : acc;
                end
            end
            default: ;
        endcase
    end

    // start_q resets to 1 so a start held high through reset is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            start_q <= 1'b1;
            y_r     <= '0;
            xb      <= '0;
            k       <= '0;
            z       <= '0;
            done1   <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (launch) begin
                        y_r   <= y;
                        done1 <= 1'b0;
                        state <= ST_PRE_X;
                    end
                end
                ST_PRE_X: begin
                    if (mm_rdy) begin
                        xb    <= acc;
                        state <= ST_PRE_1;
                    end
                end
                ST_PRE_1: begin
                    if (mm_rdy) begin
                        k     <= KW'(WIDTH - 1);
                        state <= ST_SQR;
                    end
                end
                ST_SQR: begin
                    if (mm_rdy) begin
                        if (bit_set) begin
                            state <= ST_MUL;
                        end else if (k_last) begin
                            state <= ST_POST;
                        end else begin
                            k <= k - 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mm_rdy) begin
                        if (k_last) begin
                            state <= ST_POST;
                        end else begin
                            k     <= k - 1'b1;
                            state <= ST_SQR;
                        end
                    end
                end
                ST_POST: begin
                    if (mm_rdy) begin
                        z     <= acc;
                        done1 <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mont_mult #(.W(WIDTH)) u_mm (
        .clk   (clk),
        .reset (reset),
        .go    (mm_go),
        .a     (mm_a),
        .b     (mm_b),
        .m     (MODULUS),
        .p     (acc),
        .rdy   (mm_rdy)
    );

endmodule

// File: tb/tb_mont_expo_192.sv
// Bench for mont_expo_192: a full-width instance for the 192-bit vector and a
// 32-bit instance (prime modulus 2^32-5) for control and edge-case scenarios.
module tb_mont_expo_192;

    localparam logic [191:0] M_B = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff;
    localparam logic [31:0]  M_S = 32'hfffffffb;

    logic         clk;
    logic         rst;
    logic         start_b;
    logic [191:0] x_b;
    logic [191:0] y_b;
    logic [191:0] z_b;
    logic         done_b;
    logic [2:0]   st_b;
    logic         start_s;
    logic [31:0]  x_s;
    logic [31:0]  y_s;
    logic [31:0]  z_s;
    logic         done_s;
    logic [2:0]   st_s;

    int errors;
    int checks;
    logic [31:0] last_exp_s;

    mont_expo_192 dut_b (
        .clk(clk), .reset(rst), .x(x_b), .y(y_b), .start(start_b),
        .z(z_b), .done1(done_b), .dbg_state(st_b)
    );

    mont_expo_192 #(.WIDTH(32), .MODULUS(32'hfffffffb), .R2(32'd25)) dut_s (
        .clk(clk), .reset(rst), .x(x_s), .y(y_s), .start(start_s),
        .z(z_s), .done1(done_s), .dbg_state(st_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain right-to-left modular exponentiation on wide integers.
    function automatic logic [191:0] ref_pow(input logic [191:0] base, input logic [191:0] e,
                                             input logic [191:0] md, input int w);
        logic [383:0] r, bb, mm;
        mm = {192'b0, md};
        bb = {192'b0, base} % mm;
        r  = 384'd1 % mm;
        for (int i = 0; i < w; i++) begin
            if (e[i]) r = (r * bb) % mm;
            bb = (bb * bb) % mm;
        end
        return r[191:0];
    endfunction

    function automatic logic [31:0] ref_pow_s(input logic [31:0] base, input logic [31:0] e);
        logic [191:0] r;
        r = ref_pow({160'b0, base}, {160'b0, e}, {160'b0, M_S}, 32);
        return r[31:0];
    endfunction

    function automatic int bound_of(input int w, input int ones);
        return (3 + w + ones) * (w + 2) + 4;
    endfunction

    task automatic launch_s(input logic [31:0] xv, input logic [31:0] yv);
        @(negedge clk);
        start_s = 1'b0;
        @(negedge clk);
        x_s = xv;
        y_s = yv;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
    endtask

    task automatic launch_b(input logic [191:0] xv, input logic [191:0] yv);
        @(negedge clk);
        start_b = 1'b0;
        @(negedge clk);
        x_b = xv;
        y_b = yv;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    // Returns the number of edges elapsed after the launch edge when done1 is seen.
    task automatic wait_s(input int budget, output int elapsed, output bit seen);
        int c;
        seen = 1'b0;
        c = 1;
        while (c <= budget + 1 && !seen) begin
            if (done_s) seen = 1'b1;
            else begin
                @(negedge clk);
                c++;
            end
        end
        elapsed = c - 1;
    endtask

    task automatic wait_b(input int budget, output int elapsed, output bit seen);
        int c;
        seen = 1'b0;
        c = 1;
        while (c <= budget + 1 && !seen) begin
            if (done_b) seen = 1'b1;
            else begin
                @(negedge clk);
                c++;
            end
        end
        elapsed = c - 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_s = 1'b1;
        start_b = 1'b0;
        x_s = 32'd7;
        y_s = 32'd1;
        x_b = '0;
        y_b = '0;
        repeat (3) @(negedge clk);
        checks++; if (z_s !== 32'd0) begin errors++; $display("FAIL reset_z_s: got %0h expected 0", z_s); end
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL reset_done_s: got %0b expected 0", done_s); end
        checks++; if (z_b !== 192'd0) begin errors++; $display("FAIL reset_z_b: got %0h expected 0", z_b); end
        checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL reset_done_b: got %0b expected 0", done_b); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL held_start_done: got %0b expected 0", done_s); end
    endtask

    // start has been high since reset; only the later 0->1 edge may launch.
    task automatic test_launch_seq();
        int el;
        bit seen;
        bit stable;
        launch_s(32'd3, 32'd3);
        x_s = 32'd11;
        y_s = 32'd5;
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL launch_done_low: got %0b expected 0", done_s); end
        wait_s(bound_of(32, 2), el, seen);
        checks++; if (!seen) begin errors++; $display("FAIL launch_timeout: got no done1 after %0d cycles expected done1", el); end
        checks++; if (z_s !== 32'd27) begin errors++; $display("FAIL launch_z: got %0d expected 27", z_s); end
        checks++; if (el > bound_of(32, 2)) begin errors++; $display("FAIL launch_latency: got %0d expected <= %0d", el, bound_of(32, 2)); end
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done_s !== 1'b1 || z_s !== 32'd27) stable = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL done_hold: got done1=%0b z=%0d expected 1 and 27", done_s, z_s); end
        last_exp_s = 32'd27;
    endtask

    task automatic test_edges();
        logic [31:0] ex_x [4];
        logic [31:0] ex_y [4];
        logic [31:0] ex_z [4];
        int el;
        bit seen;
        ex_x = '{32'd5, M_S - 32'd1, 32'd0, M_S + 32'd2};
        ex_y = '{32'd0, 32'd2, 32'd7, 32'd1};
        ex_z = '{32'd1, 32'd1, 32'd0, 32'd2};
        for (int i = 0; i < 4; i++) begin
            launch_s(ex_x[i], ex_y[i]);
            wait_s(bound_of(32, $countones(ex_y[i])), el, seen);
            checks++;
            if (!seen || z_s !== ex_z[i]) begin
                errors++;
                $display("FAIL edge_%0d: got z=%0h done1=%0b expected z=%0h done1=1", i, z_s, seen, ex_z[i]);
            end
            last_exp_s = ex_z[i];
        end
    endtask

    task automatic test_busy_window();
        logic [31:0] xa, ya, exp_z;
        int el, pre;
        bit seen;
        xa = $urandom;
        ya = $urandom;
        exp_z = ref_pow_s(xa, ya);
        launch_s(xa, ya);
        pre = $urandom_range(100, 400);
        repeat (pre) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            x_s = $urandom;
            y_s = $urandom;
            start_s = ~start_s;
            @(negedge clk);
        end
        start_s = 1'b0;
        wait_s(bound_of(32, $countones(ya)) - pre - 6, el, seen);
        el = el + pre + 6;
        checks++; if (!seen) begin errors++; $display("FAIL busy_timeout: got no done1 after %0d cycles expected done1", el); end
        checks++; if (z_s !== exp_z) begin errors++; $display("FAIL busy_z: got %0h expected %0h", z_s, exp_z); end
        last_exp_s = exp_z;
    endtask

    task automatic test_back_to_back();
        logic [31:0] xa, ya, exp_z;
        int el;
        bit seen;
        xa = $urandom;
        ya = $urandom;
        exp_z = ref_pow_s(xa, ya);
        launch_s(xa, ya);
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %0b expected 0", done_s); end
        checks++; if (z_s !== last_exp_s) begin errors++; $display("FAIL b2b_z_hold: got %0h expected %0h", z_s, last_exp_s); end
        wait_s(bound_of(32, $countones(ya)), el, seen);
        checks++; if (!seen || z_s !== exp_z) begin errors++; $display("FAIL b2b_z: got %0h done1=%0b expected %0h", z_s, seen, exp_z); end
        last_exp_s = exp_z;
    endtask

    task automatic test_random();
        logic [31:0] xa, ya, exp_z;
        int el;
        bit seen;
        for (int i = 0; i < 3; i++) begin
            xa = $urandom;
            ya = $urandom;
            exp_z = ref_pow_s(xa, ya);
            launch_s(xa, ya);
            wait_s(bound_of(32, $countones(ya)), el, seen);
            checks++;
            if (!seen || z_s !== exp_z) begin
                errors++;
                $display("FAIL random_%0d: x=%0h y=%0h got %0h done1=%0b expected %0h", i, xa, ya, z_s, seen, exp_z);
            end
            last_exp_s = exp_z;
        end
    endtask

    task automatic test_reset_abort();
        int el;
        bit seen;
        launch_s($urandom, $urandom);
        repeat (600) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (z_s !== 32'd0) begin errors++; $display("FAIL abort_z: got %0h expected 0", z_s); end
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL abort_done: got %0b expected 0", done_s); end
        @(negedge clk);
        rst = 1'b0;
        launch_s(32'd2, 32'd10);
        wait_s(bound_of(32, 2), el, seen);
        checks++; if (!seen || z_s !== 32'd1024) begin errors++; $display("FAIL abort_relaunch: got %0d done1=%0b expected 1024", z_s, seen); end
    endtask

    task automatic test_big_vector();
        logic [191:0] xa, ya, exp_z;
        int el;
        bit seen;
        xa = 192'h6543210fedcba9876543210fedcba9876543210fedcba987;
        ya = 192'hfedcba9876543210fedcba9876543210fedcba9876543210;
        exp_z = ref_pow(xa, ya, M_B, 192);
        launch_b(xa, ya);
        checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL big_done_low: got %0b expected 0", done_b); end
        wait_b(bound_of(192, $countones(ya)), el, seen);
        checks++; if (!seen) begin errors++; $display("FAIL big_timeout: got no done1 after %0d cycles expected done1", el); end
        checks++; if (z_b !== exp_z) begin errors++; $display("FAIL big_z: got %0h expected %0h", z_b, exp_z); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        last_exp_s = '0;
        test_reset();
        test_launch_seq();
        test_edges();
        test_busy_window();
        test_back_to_back();
        test_random();
        test_reset_abort();
        test_big_vector();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
